// File: rtl/pe_mac_sequencer_if.sv
// Scratchpad read, multiplier and psum-output signals of one PE MAC sequencer.
// master = sequencer side, slave = spads / multiplier / psum consumer.
interface pe_mac_sequencer_if #(
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
);
  localparam int PSUM_WIDTH = 2 * PIXEL_WIDTH;

  logic                          spad_rd_en;
  logic [ADDR_WIDTH-1:0]         ifmap_addr;
  logic [ADDR_WIDTH-1:0]         filt_addr;
  logic signed [PIXEL_WIDTH-1:0] ifmap_data;
  logic signed [PIXEL_WIDTH-1:0] filt_data;
  logic                          mul_enable;
  logic signed [PIXEL_WIDTH-1:0] mul_a;
  logic signed [PIXEL_WIDTH-1:0] mul_b;
  logic signed [PSUM_WIDTH-1:0]  mul_product;
  logic signed [PSUM_WIDTH-1:0]  psum_out;
  logic                          psum_valid;
  logic                          psum_ready;

  modport master (
    output spad_rd_en, ifmap_addr, filt_addr, mul_enable, mul_a, mul_b, psum_out, psum_valid,
    input  ifmap_data, filt_data, mul_product, psum_ready
  );

  modport slave (
    input  spad_rd_en, ifmap_addr, filt_addr, mul_enable, mul_a, mul_b, psum_out, psum_valid,
    output ifmap_data, filt_data, mul_product, psum_ready
  );
endinterface

// File: rtl/pe_mac_sequencer.sv
// Sequences one PE job: N psums, each an L-tap dot product of ifmap and filter
// scratchpad reads, with zero-skip multiplies and a valid/ready psum output.
module pe_mac_sequencer #(
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] filt_len,
  input  logic [ADDR_WIDTH-1:0] num_psums,
  input  logic [ADDR_WIDTH-1:0] ifmap_base,
  input  logic [ADDR_WIDTH-1:0] filt_base,
  output logic                  busy,
  output logic                  done,
  pe_mac_sequencer_if.master    bus
);
  localparam int PSUM_WIDTH = 2 * PIXEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_OUT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]        len_q, num_q, ifmap_base_q, filt_base_q;
  logic [ADDR_WIDTH-1:0]        tap_q, psum_idx_q;
  logic signed [PSUM_WIDTH-1:0] acc_q;
  logic                         mul_stage_q;
  logic                         mul_en;

  wire last_tap  = (tap_q == len_q - ONE);
  wire last_psum = (psum_idx_q == num_q - ONE);
  wire cfg_empty = (filt_len == '0) || (num_psums == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = cfg_empty ? S_DONE : S_RUN;
      S_RUN:   if (last_tap) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_OUT;
      S_OUT:   if (bus.psum_ready) state_nxt = last_psum ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data returns one cycle after each RUN cycle; that cycle is the MUL stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      num_q        <= '0;
      ifmap_base_q <= '0;
      filt_base_q  <= '0;
      tap_q        <= '0;
      psum_idx_q   <= '0;
      acc_q        <= '0;
      mul_stage_q  <= 1'b0;
    end else begin
      mul_stage_q <= (state == S_RUN);
      if (mul_stage_q) acc_q <= acc_q + (mul_en ? bus.mul_product : '0);
      unique case (state)
        S_IDLE: if (start) begin
          len_q        <= filt_len;
          num_q        <= num_psums;
          ifmap_base_q <= ifmap_base;
          filt_base_q  <= filt_base;
          tap_q        <= '0;
          psum_idx_q   <= '0;
          acc_q        <= '0;
        end
        S_RUN: tap_q <= tap_q + ONE;
        S_OUT: if (bus.psum_ready && !last_psum) begin
          psum_idx_q <= psum_idx_q + ONE;
          tap_q      <= '0;
          acc_q      <= '0;
        end
        default: ;
      endcase
    end
  end

  // Zero operands skip the multiply; operands themselves pass straight through.
  assign mul_en = mul_stage_q && (bus.ifmap_data != '0) && (bus.filt_data != '0);

  always_comb begin
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    bus.spad_rd_en = 1'b0;
    bus.ifmap_addr = '0;
    bus.filt_addr  = '0;
    bus.mul_enable = mul_en;
    bus.mul_a      = '0;
    bus.mul_b      = '0;
    bus.psum_valid = 1'b0;
    bus.psum_out   = '0;
    if (state == S_RUN) begin
      bus.spad_rd_en = 1'b1;
      bus.ifmap_addr = ifmap_base_q + psum_idx_q + tap_q;
      bus.filt_addr  = filt_base_q + tap_q;
    end
    if (mul_stage_q) begin
      bus.mul_a = bus.ifmap_data;
      bus.mul_b = bus.filt_data;
    end
    if (state == S_OUT) begin
      bus.psum_valid = 1'b1;
      bus.psum_out   = acc_q;
    end
  end
endmodule
